mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while inst_req waits.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port inst_req, input, 1: fetch request; held high with inst_addr stable until inst_ack.
REQ-005 SHALL have port inst_addr, input, 32: fetch address.
REQ-006 SHALL have port inst_ack, output, 1: fetch accepted this cycle.
REQ-007 SHALL have port inst_rvalid, output, 1: inst_rdata valid, one cycle.
REQ-008 SHALL have port inst_rdata, output, 32: fetched word.
REQ-009 SHALL have port data_req, input, 1: load/store request; held high with data_we, data_addr and data_wdata stable until data_ack.
REQ-010 SHALL have ports data_we (input, 1), data_addr (input, 32), data_wdata (input, 32): store enable, address, store data.
REQ-011 SHALL have ports data_ack (output, 1), data_rvalid (output, 1), data_rdata (output, 32): data accept, load-data valid, load word.
REQ-012 SHALL have ports sram_we (output, 1), sram_addr (output, 32), sram_wdata (output, 32), sram_rdata (input, 32): shared single-port SRAM; read data returns one cycle after address.

Function
REQ-013 SHALL grant at most one requester per cycle; grant, ack and SRAM drive are combinational in the same cycle.
REQ-014 SHALL drive sram_addr, sram_we and sram_wdata from the granted requester; sram_we = data_we for a data grant, else 0.
REQ-015 SHALL drive sram_we=0, sram_addr=0 and sram_wdata=0 when no grant.
REQ-016 SHALL, when only one requester is active, grant it.
REQ-017 SHALL, when both requesters are active, grant data unless streak==STARVE_LIMIT, in which case it grants inst.
REQ-018 SHALL increment streak (saturating at STARVE_LIMIT) on each data grant while inst_req=1, and clear it on an inst grant or any cycle with inst_req=0.
REQ-019 SHALL register the owner of each read grant (NONE/INST/DATA); in the next cycle it asserts the owner's rvalid for one cycle and routes sram_rdata to that owner's rdata.
REQ-020 SHALL drive both rdata ports to 0 whenever their rvalid is 0.
REQ-021 SHALL set owner to NONE for a store grant: no rvalid follows a store.
REQ-022 SHALL support back-to-back grants every cycle: a new grant may coincide with the rvalid of the previous read.
REQ-023 SHALL leave ack low for a requester that is not granted; its request stays pending with no timeout.

Reset
REQ-024 SHALL, while reset=1, hold all acks, rvalids, sram_we, sram_addr, sram_wdata and rdata at 0, grant nothing, and load streak=0 and owner=NONE.
REQ-025 SHALL suppress rvalid in the cycle after reset for a read granted in the cycle before reset was asserted.

Structure
REQ-026 SHALL place the owner encoding (OWN_NONE=0, OWN_INST=1, OWN_DATA=2) and the STARVE_LIMIT default in shared package mem_arb_pkg.
REQ-027 SHALL put grant selection plus the streak counter in one sub-module, mem_arb_prio; the top holds the owner register and muxing.

Verification
REQ-028 SHALL cover: inst_req only, inst_addr=0x1C000000 -> inst_ack same cycle, sram_addr=0x1C000000; next cycle inst_rvalid=1 and inst_rdata=sram_rdata.
REQ-029 SHALL cover: data_req with data_we=1, addr=0x100, wdata=0xDEADBEEF -> sram_we=1, sram_wdata=0xDEADBEEF, data_ack=1; no rvalid the next cycle.
REQ-030 SHALL cover: both requests held for 6 cycles with STARVE_LIMIT=4 -> data granted in cycles 0-3, inst in cycle 4, data in cycle 5.
REQ-031 SHALL cover: alternating inst/data reads on consecutive cycles -> each rvalid lands on the correct port exactly one cycle after its grant.
REQ-032 SHALL cover: read granted, then reset in the next cycle -> no rvalid; all outputs 0 and streak 0 after reset.
REQ-033 SHALL cover: no requests -> sram_we=0, sram_addr=0, both acks 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding and default starvation limit for the memory port arbiter
package mem_arb_pkg;
    localparam int STARVE_LIMIT_DEF = 4;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } own_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: instruction, data and shared SRAM signals of the memory port arbiter
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
        output inst_ack, inst_rvalid, inst_rdata, data_ack, data_rvalid, data_rdata,
               sram_we, sram_addr, sram_wdata
    );
    modport master (
        output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
        input  inst_ack, inst_rvalid, inst_rdata, data_ack, data_rvalid, data_rdata,
               sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first grant selection with a streak counter that bounds instruction starvation
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inst_req,
    input  logic i_data_req,
    output logic o_gnt_inst,
    output logic o_gnt_data
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    logic [SW-1:0] r_streak;
    logic          w_at_limit;
    // Data wins a conflict until the waiting fetch has been passed over STARVE_LIMIT times
    always_comb begin
        w_at_limit = r_streak == LIMIT;
        o_gnt_data = !reset && i_data_req && !(i_inst_req && w_at_limit);
        o_gnt_inst = !reset && i_inst_req && !o_gnt_data;
    end
    // Count data grants that bypass a waiting fetch; any fetch grant or idle fetch side clears it
    always_ff @(posedge clk) begin
        if (reset || !i_inst_req || o_gnt_inst)
            r_streak <= '0;
        else if (o_gnt_data && !w_at_limit)
            r_streak <= r_streak + SW'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between instruction fetch and load/store ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic                 clk,
    input logic                 reset,
    mem_port_arbiter_if.slave   bus
);
    logic w_gnt_inst;
    logic w_gnt_data;
    own_t r_owner;

    mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk        (clk),
        .reset      (reset),
        .i_inst_req (bus.inst_req),
        .i_data_req (bus.data_req),
        .o_gnt_inst (w_gnt_inst),
        .o_gnt_data (w_gnt_data)
    );

    // Drive the SRAM from the granted port and return read data to the owner of last cycle's read
    always_comb begin
        bus.inst_ack    = w_gnt_inst;
        bus.data_ack    = w_gnt_data;
        bus.sram_we     = w_gnt_data && bus.data_we;
        bus.sram_addr   = w_gnt_inst ? bus.inst_addr : w_gnt_data ? bus.data_addr : '0;
        bus.sram_wdata  = w_gnt_data ? bus.data_wdata : '0;
        bus.inst_rvalid = !reset && r_owner == OWN_INST;
        bus.data_rvalid = !reset && r_owner == OWN_DATA;
        bus.inst_rdata  = bus.inst_rvalid ? bus.sram_rdata : '0;
        bus.data_rdata  = bus.data_rvalid ? bus.sram_rdata : '0;
    end

    // Remember who issued this cycle's read; stores and idle cycles own nothing
    always_ff @(posedge clk) begin
        r_owner <= reset ? OWN_NONE :
                   w_gnt_inst ? OWN_INST :
                   (w_gnt_data && !bus.data_we) ? OWN_DATA : OWN_NONE;
    end
endmodule
